demod_pack: RTL
===============

DEMOD_PACK -- requirements
Module: demod_pack

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output FIFO entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  clock; all state SHALL update on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 sym_in  input  5  5-bit symbol, LSB-first bit order, as produced by the Mod stage's dmod output.
REQ-005 sym_valid  input  1  sym_in valid; driven from the Mod stage's mod_en.
REQ-006 sym_rdy  output  1  block can accept a symbol this cycle.
REQ-007 align  input  1  synchronous frame realign; discards partial bits and restarts the frame.
REQ-008 byte_out  output  8  reassembled byte at FIFO head.
REQ-009 byte_last  output  1  byte_out is the 5th byte of a 40-bit frame.
REQ-010 byte_valid  output  1  FIFO non-empty; byte_out and byte_last valid.
REQ-011 byte_rdy  input  1  downstream accepts byte_out.
REQ-012 fifo_level  output  5  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-013 Accumulator acc[11:0] with bit count cnt, 0..12; cnt SHALL never exceed 12.
REQ-014 sym_rdy SHALL be 1 iff cnt < 8 and align = 0.
REQ-015 Accept when sym_valid and sym_rdy: acc bits [cnt+4:cnt] <= sym_in, cnt <= cnt+5; bits above cnt+4 unchanged.
REQ-016 Extract when cnt >= 8 and fifo_level < FIFO_DEPTH: push {acc[7:0], last}; acc <= acc >> 8; cnt <= cnt-8.
REQ-017 Accept and extract are mutually exclusive by REQ-014; accept and extract SHALL never both occur in one cycle.
REQ-018 Frame byte index fidx, 0..4: increments on every push and wraps 4->0; last = (fidx == 4).
REQ-019 Push with FIFO full SHALL NOT occur; extraction stalls and acc/cnt hold.
REQ-020 A same-cycle pop does not free a slot for push; push eligibility uses fifo_level before the edge.
REQ-021 Pop when byte_valid and byte_rdy: head advances; simultaneous push and pop leaves fifo_level unchanged.
REQ-022 byte_valid SHALL be 1 iff fifo_level != 0; byte_out/byte_last combinationally reflect the head entry.
REQ-023 Latency: a symbol that brings cnt to >= 8 is accepted at edge N; its byte is pushed at edge N+1 if FIFO not full; byte_valid is 1 after edge N+1.
REQ-024 Throughput: 8 symbols yield 5 bytes; sym_rdy deasserts for exactly 1 cycle per extracted byte when FIFO not full.
REQ-025 align = 1: at the next edge cnt <= 0, acc <= 0, fidx <= 0; no accept or extract that cycle.
REQ-026 align SHALL NOT affect FIFO contents, fifo_level, or a pop in the same cycle.
REQ-027 sym_valid while sym_rdy = 0 SHALL be ignored; the symbol is not stored.

Reset
REQ-028 reset_n low SHALL asynchronously clear acc, cnt, fidx, FIFO pointers, and entries.
REQ-029 During and after reset, until the first push: sym_rdy = 1 (if align = 0), byte_valid = 0, byte_out = 8'h00, byte_last = 0, fifo_level = 0.
REQ-030 Reset mid-frame SHALL discard all partial bits and queued bytes; the first symbol after release starts a new frame at bit 0.

Verification
REQ-031 After reset, byte_rdy = 1, feed symbols 11,10,08,06,03,02,15,0A (hex) -> bytes 11,22,33,44,55; byte_last only on 55.
REQ-032 Same stream, byte_rdy = 0 -> FIFO fills to 4 (11,22,33,44); cnt stalls at >= 8; sym_rdy = 0; byte_rdy = 1 then drains all 5 bytes in order with no loss.
REQ-033 Feed 3 symbols (cnt = 7 after 1 extract), pulse align, then the REQ-031 stream -> exactly 11,22,33,44,55 follow the earlier byte; fidx restarted; byte_last on 55.
REQ-034 Hold sym_valid = 1 continuously; check that sym_rdy pattern produces 5 extract bubbles per 8 symbols and that no accept occurs when cnt >= 8.
REQ-035 Full FIFO with simultaneous pop and pending extract -> the pop occurs, push waits 1 cycle, and fifo_level goes 4 -> 3 -> 4.
REQ-036 Assert reset_n low mid-stream with bytes queued -> byte_valid = 0 and fifo_level = 0 immediately; sym_rdy = 1.

Source files
------------

// File: rtl/demod_pack.sv
// Repacks a stream of 5-bit symbols (LSB first) into bytes, tagging every 5th byte
// as the end of a 40-bit frame, and queues them in a small output FIFO.
module demod_pack #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_rdy,
  input  logic       align,
  output logic [7:0] byte_out,
  output logic       byte_last,
  output logic       byte_valid,
  input  logic       byte_rdy,
  output logic [4:0] fifo_level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [11:0]      acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       fidx_q, fidx_d;
  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]       level_q, level_d;

  logic        accept;
  logic        extract;
  logic        pop;
  logic        last;
  logic [11:0] ins_mask;
  logic [11:0] ins_bits;

  // Accept only below 8 bits, so accept and extract can never coincide.
  assign sym_rdy  = (cnt_q < 4'd8) && !align;
  assign accept   = sym_valid && sym_rdy;
  assign extract  = (cnt_q >= 4'd8) && (level_q < 5'(FIFO_DEPTH)) && !align;
  assign pop      = byte_valid && byte_rdy;
  assign last     = (fidx_q == 3'd4);
  assign ins_mask = 12'h01F << cnt_q;
  assign ins_bits = {7'd0, sym_in} << cnt_q;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    fidx_d = fidx_q;
    if (align) begin
      acc_d  = '0;
      cnt_d  = '0;
      fidx_d = '0;
    end else if (accept) begin
      acc_d = (acc_q & ~ins_mask) | ins_bits;
      cnt_d = cnt_q + 4'd5;
    end else if (extract) begin
      acc_d  = acc_q >> 8;
      cnt_d  = cnt_q - 4'd8;
      fidx_d = last ? 3'd0 : fidx_q + 3'd1;
    end
  end

  // Push eligibility uses the pre-edge level, so a same-cycle pop never frees a slot.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (extract) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({extract, pop})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      fidx_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      fidx_q   <= fidx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (extract) begin
      mem_q[wr_ptr_q] <= {last, acc_q[7:0]};
    end
  end

  assign byte_out   = mem_q[rd_ptr_q][7:0];
  assign byte_last  = mem_q[rd_ptr_q][8];
  assign byte_valid = (level_q != 5'd0);
  assign fifo_level = level_q;

endmodule
